// File: rtl/stream_accumulator.sv
// Packet accumulator for signed operands on a valid/ready stream. The packet total,
// final carry-out, sticky overflow and beat count are reported on a valid/ready result port.

module stream_accumulator_rca #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);
  logic [W:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < W; g++) begin : g_bit
    assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_c[W];
endmodule

// state   | meaning
// S_IDLE  | waiting for the first beat of a packet; accumulator is zero
// S_ACCUM | beats accepted, last beat not yet seen
// S_DONE  | result presented on out_*, waiting for out_ready
module stream_accumulator #(
  parameter int WIDTH    = 32,
  parameter int CNT_W    = 16,
  parameter int SATURATE = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_last,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_sum,
  output logic             o_out_cout,
  output logic             o_out_overflow,
  output logic [CNT_W-1:0] o_out_count
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic             r_cout;
  logic             r_ovf;
  logic [CNT_W-1:0] r_count;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_accept;
  logic             w_v;
  logic [WIDTH-1:0] w_acc_next;
  logic [CNT_W-1:0] w_count_next;

  stream_accumulator_rca #(.W(WIDTH)) u_adder (
    .i_a    (r_acc),
    .i_b    (i_in_data),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_carry)
  );

  assign w_accept = i_in_valid && r_in_ready;
  assign w_v      = (r_acc[WIDTH-1] == i_in_data[WIDTH-1]) && (w_sum[WIDTH-1] != r_acc[WIDTH-1]);

  // Overflow direction follows the sign of the operands, which equals the old accumulator sign.
  always_comb begin
    w_acc_next = w_sum;
    if (SATURATE != 0 && w_v) begin
      w_acc_next = r_acc[WIDTH-1] ? MIN_NEG : MAX_POS;
    end
  end

  assign w_count_next = (&r_count) ? r_count : r_count + CNT_ONE;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (i_clear) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_acc   <= w_acc_next;
            r_cout  <= w_carry;
            r_ovf   <= r_ovf | w_v;
            r_count <= w_count_next;
            if (i_in_last) begin
              r_state     <= S_DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready     = r_in_ready;
  assign o_out_valid    = r_out_valid;
  assign o_out_sum      = r_acc;
  assign o_out_cout     = r_cout;
  assign o_out_overflow = r_ovf;
  assign o_out_count    = r_count;
endmodule

// File: tb/tb_stream_accumulator.sv
// Bench for stream_accumulator: a wrapping instance (16-bit counter) and a saturating
// instance (3-bit counter) share one stimulus stream and are checked side by side.

module tb_stream_accumulator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;

  logic        rdy_w, val_w, cout_w, ovf_w;
  logic [31:0] sum_w;
  logic [15:0] cnt_w;
  logic        rdy_s, val_s, cout_s, ovf_s;
  logic [31:0] sum_s;
  logic [2:0]  cnt_s;

  int n_checks = 0;
  int n_fail   = 0;

  localparam longint MAXP = 64'sd2147483647;
  localparam longint MINN = -64'sd2147483648;
  localparam longint MOD  = 64'sd4294967296;

  stream_accumulator #(.WIDTH(32), .CNT_W(16), .SATURATE(0)) dut_w (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear),
    .i_in_valid(in_valid), .o_in_ready(rdy_w), .i_in_data(in_data), .i_in_last(in_last),
    .o_out_valid(val_w), .i_out_ready(out_ready), .o_out_sum(sum_w),
    .o_out_cout(cout_w), .o_out_overflow(ovf_w), .o_out_count(cnt_w)
  );

  stream_accumulator #(.WIDTH(32), .CNT_W(3), .SATURATE(1)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear),
    .i_in_valid(in_valid), .o_in_ready(rdy_s), .i_in_data(in_data), .i_in_last(in_last),
    .o_out_valid(val_s), .i_out_ready(out_ready), .o_out_sum(sum_s),
    .o_out_cout(cout_s), .o_out_overflow(ovf_s), .o_out_count(cnt_s)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  typedef struct {
    int          n;
    int          d[10];
    logic [31:0] sum_w;
    logic [31:0] sum_s;
    bit          cout;
    bit          ovf;
    int          cnt_w;
    int          cnt_s;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact integer sum per beat, then wrap or clamp to the 32-bit signed range.
  function automatic void model(input int beats[$], input bit sat, input int cw,
                                output logic [31:0] s, output bit c, output bit o, output int n);
    longint a = 0;
    longint t, ua, ud;
    c = 1'b0;
    o = 1'b0;
    foreach (beats[i]) begin
      ua = a & 64'hFFFF_FFFF;
      ud = longint'(beats[i]) & 64'hFFFF_FFFF;
      c  = ((ua + ud) >> 32) != 0;
      t  = a + longint'(beats[i]);
      if (t > MAXP || t < MINN) begin
        o = 1'b1;
        if (sat) a = (t > 0) ? MAXP : MINN;
        else     a = (t > 0) ? t - MOD : t + MOD;
      end else begin
        a = t;
      end
    end
    s = a[31:0];
    n = (beats.size() > (1 << cw) - 1) ? (1 << cw) - 1 : beats.size();
  endfunction

  task automatic send_beat(input logic [31:0] d, input bit last);
    int g = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!rdy_w && g < 100) begin
      tick();
      g++;
    end
    if (g >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic wait_valid();
    int g = 0;
    while (!val_w && g < 50) begin
      tick();
      g++;
    end
    check("result_valid", val_w, 1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hs_valid_drop", val_w, 0);
    check("hs_ready_back", rdy_w, 1);
    check("hs_acc_clear", sum_w, 0);
    check("hs_cnt_clear", cnt_w, 0);
  endtask

  task automatic run_packet(input int q[$], input int gap_max, input int hold);
    logic [31:0] es;
    bit          ec, eo;
    int          en;
    foreach (q[i]) begin
      send_beat(q[i], i == q.size() - 1);
      if (i != q.size() - 1) begin
        repeat ($urandom_range(0, gap_max)) tick();
      end
    end
    repeat (hold) tick();
    wait_valid();
    model(q, 1'b0, 16, es, ec, eo, en);
    check("rnd_sum_w", sum_w, es);
    check("rnd_cout_w", cout_w, ec);
    check("rnd_ovf_w", ovf_w, eo);
    check("rnd_cnt_w", cnt_w, en);
    model(q, 1'b1, 3, es, ec, eo, en);
    check("rnd_valid_s", val_s, 1);
    check("rnd_sum_s", sum_s, es);
    check("rnd_cout_s", cout_s, ec);
    check("rnd_ovf_s", ovf_s, eo);
    check("rnd_cnt_s", cnt_s, en);
    handshake();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_val"}, {val_w, val_s}, 0);
    check({tag, "_sum"}, {sum_w, sum_s}, 0);
    check({tag, "_flags"}, {cout_w, ovf_w, cout_s, ovf_s}, 0);
    check({tag, "_cnt"}, {cnt_w, cnt_s}, 0);
  endtask

  initial begin
    int q[$];
    int w;

    vecs[0] = '{3, '{100, -200, 50, 0, 0, 0, 0, 0, 0, 0}, 32'hFFFF_FFCE, 32'hFFFF_FFCE, 1'b0, 1'b0, 3, 3};
    vecs[1] = '{2, '{2147483647, 1, 0, 0, 0, 0, 0, 0, 0, 0}, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 2, 2};
    vecs[2] = '{2, '{int'(32'h8000_0000), -1, 0, 0, 0, 0, 0, 0, 0, 0}, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 2, 2};
    vecs[3] = '{1, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 32'h0, 32'h0, 1'b0, 1'b0, 1, 1};
    vecs[4] = '{3, '{2147483647, 1, -1, 0, 0, 0, 0, 0, 0, 0}, 32'h7FFF_FFFF, 32'h7FFF_FFFE, 1'b1, 1'b1, 3, 3};
    vecs[5] = '{4, '{-1, -1, -1, -1, 0, 0, 0, 0, 0, 0}, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b0, 4, 4};
    vecs[6] = '{9, '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0}, 32'h9, 32'h9, 1'b0, 1'b0, 9, 7};

    // Reset state
    #2;
    check_all_zero("reset");
    check("reset_in_ready", {rdy_w, rdy_s}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", {rdy_w, rdy_s}, 2'b11);

    // Directed vectors
    foreach (vecs[k]) begin
      for (int i = 0; i < vecs[k].n; i++) send_beat(vecs[k].d[i], i == vecs[k].n - 1);
      check($sformatf("v%0d_latency", k), {val_w, val_s}, 2'b11);
      check($sformatf("v%0d_sum_w", k), sum_w, vecs[k].sum_w);
      check($sformatf("v%0d_sum_s", k), sum_s, vecs[k].sum_s);
      check($sformatf("v%0d_cout", k), {cout_w, cout_s}, {vecs[k].cout, vecs[k].cout});
      check($sformatf("v%0d_ovf", k), {ovf_w, ovf_s}, {vecs[k].ovf, vecs[k].ovf});
      check($sformatf("v%0d_cnt_w", k), cnt_w, vecs[k].cnt_w);
      check($sformatf("v%0d_cnt_s", k), cnt_s, vecs[k].cnt_s);
      handshake();
    end

    // Backpressure with a beat offered while DONE
    send_beat(1234, 1'b0);
    send_beat(-5678, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'd999;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", val_w, 1);
      check("bp_sum", sum_w, 32'hFFFF_EEA4);
      check("bp_in_ready", rdy_w, 0);
      check("bp_cnt", cnt_w, 2);
      tick();
    end
    in_valid = 1'b0;
    handshake();
    send_beat(0, 1'b1);
    check("bp_next_sum", sum_w, 0);
    check("bp_next_cnt", cnt_w, 1);
    check("bp_next_ovf", ovf_w, 0);
    handshake();

    // Gap inside a packet
    send_beat(7, 1'b0);
    repeat (3) begin
      tick();
      check("gap_hold", {val_w, sum_w, cnt_w}, {1'b0, 32'd7, 16'd1});
    end
    send_beat(8, 1'b1);
    check("gap_sum", sum_w, 15);
    check("gap_cnt", cnt_w, 2);
    handshake();

    // Synchronous clear with a colliding beat
    send_beat(10, 1'b0);
    send_beat(20, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd99;
    in_last  = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_all_zero("clear");
    check("clear_in_ready", rdy_w, 1);
    repeat (2) tick();
    check("clear_no_valid", val_w, 0);
    send_beat(5, 1'b1);
    check("clear_next", {sum_w, cnt_w}, {32'd5, 16'd1});
    handshake();

    // Asynchronous reset mid-packet
    send_beat(10, 1'b0);
    send_beat(20, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("arst");
    check("arst_in_ready", {rdy_w, rdy_s}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_idle", {val_w, rdy_w}, 2'b01);
    send_beat(5, 1'b1);
    check("arst_next", {sum_w, cnt_w}, {32'd5, 16'd1});
    handshake();

    // Randomized packets against the reference model
    for (int p = 0; p < 40; p++) begin
      q.delete();
      w = $urandom_range(1, 9);
      for (int b = 0; b < w; b++) begin
        case ($urandom_range(0, 4))
          0:       q.push_back(2147483647);
          1:       q.push_back(int'(32'h8000_0000));
          2:       q.push_back(-1);
          3:       q.push_back(int'($urandom_range(0, 200)) - 100);
          default: q.push_back(int'($urandom));
        endcase
      end
      run_packet(q, 2, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_accumulator.md
Name: stream_accumulator

Overview:
- Sequential stage directly downstream of the 32-bit signed ripple-carry adder datapath; it feeds operands to that adder and consumes its sum and carry-out.
- Accumulates a packet of signed two's-complement operands arriving on a valid/ready stream.
- Reports the packet total, the final carry-out, a sticky signed-overflow flag and a beat count on a valid/ready result port.
- Overflow can optionally saturate the running total.

Parameters:
- WIDTH, 32, operand and accumulator width (two's complement).
- CNT_W, 16, width of the beat counter.
- SATURATE, 0, 0 = wrap on signed overflow; 1 = clamp to most-positive / most-negative value.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort: drop packet, return to IDLE.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  WIDTH  signed operand.
- in_last  input  1  marks the final beat of a packet.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH  packet total.
- out_cout  output  1  unsigned carry-out of the last addition.
- out_overflow  output  1  sticky signed overflow over the packet.
- out_count  output  CNT_W  number of beats accepted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE.
  - acc, cout, ovf and count = 0.
  - out_valid = 0, in_ready = 0 while rst_n is low, then 1 in IDLE.
  - All out_* = 0.
- States: IDLE, ACCUM, DONE.
  - in_ready = 1 in IDLE and ACCUM; 0 in DONE.
  - out_valid = 1 only in DONE.
- Beat accept occurs when in_valid && in_ready. On accept:
  - sum = acc + in_data, with carry-in 0, using the team adder.
  - acc <= sum, or the clamp value when SATURATE=1 and overflow occurs.
  - cout <= adder carry-out.
  - ovf <= ovf | v, where v = (acc[MSB]==in_data[MSB]) && (sum[MSB]!=acc[MSB]).
  - count <= count + 1; the counter saturates at all-ones.
- Saturation (SATURATE=1):
  - Positive overflow clamps to 0x7FFFFFFF.
  - Negative overflow clamps to 0x80000000.
  - Later beats add to the clamped value.
  - ovf is still set.
- State transitions:
  - IDLE --accept, !in_last--> ACCUM.
  - IDLE/ACCUM --accept, in_last--> DONE.
  - ACCUM --accept, !in_last--> ACCUM.
  - DONE --out_ready--> IDLE; on this transition acc, cout, ovf and count clear to 0.
- Latency: last beat accepted at edge N gives out_valid = 1 from edge N, visible cycle N+1.
- out_* are registered; they equal acc, cout, ovf and count and are stable while out_valid && !out_ready.
- Back-to-back packets: the first beat of the next packet can be accepted in the cycle after the DONE handshake.
- Gaps: in_valid low in ACCUM holds all state.
- clear:
  - Highest synchronous priority, in any state.
  - Next state IDLE; registers zeroed; out_valid drops next edge.
  - A beat presented in the same cycle is discarded.
- Mid-packet rst_n: immediate zeroing; no partial result is emitted.
- in_data is ignored when in_valid = 0.
- in_valid may be asserted in DONE but is not accepted.

Test Plan:
- Packet 100, -200, 50(last), SATURATE=0:
  - out_valid is high the cycle after the last beat.
  - out_sum = -50 (0xFFFFFFCE), out_count = 3, out_overflow = 0.
- Single beat 2147483647 followed by beat 1(last):
  - SATURATE=0: out_sum = 0x80000000, out_overflow = 1, out_cout = 0.
  - SATURATE=1: out_sum = 0x7FFFFFFF, out_overflow = 1.
- Beats -2147483648 then -1(last):
  - SATURATE=0: out_sum = 0x7FFFFFFF, out_overflow = 1, out_cout = 1.
  - SATURATE=1: out_sum = 0x80000000.
- Backpressure: packet 1234, -5678(last) with out_ready low for 5 cycles:
  - out_sum = -4444 held stable and in_ready = 0 throughout.
  - When out_ready rises: one handshake, then in_ready = 1.
  - Next packet 0(last) gives out_sum = 0, out_count = 1, out_overflow = 0.
- Beats 7, gap of 3 idle cycles, then 8(last): out_sum = 15, out_count = 2.
- Abort and reset:
  - 2 beats 10, 20 then clear: IDLE, no out_valid; next packet 5(last) gives out_sum = 5, out_count = 1.
  - Repeat with rst_n pulsed low mid-cycle: all outputs 0 asynchronously; the same next-packet result follows.
